uart_fifo_bridge: RTL and testbench

- Parametrised successor to the UART loopback top: the team's rx_uart and tx cores, with a real RX FIFO and TX FIFO between them.
- Runtime mode input selects the data path:
  - Loopback mode: received bytes are echoed back out.
  - Host mode: received bytes are read by on-chip logic, and on-chip logic supplies bytes to transmit.
- Sits between board UART pins and fabric logic. Provides a sticky RX overflow flag and FIFO fill levels.

---
 rtl/uart_fifo_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: UART rx/tx cores joined by RX and TX FIFOs, with loopback and host modes
//   clk, i_reset (sync, active-high)
//   uart_txd_in -> rx_uart -> RX FIFO -> host read port (o_rd_*, i_rd_ready) or loopback transfer
//   host write port (i_wr_*, o_wr_ready) or loopback transfer -> TX FIFO -> drain FSM -> tx -> uart_rxd_out, led0_b
//   o_rx_fill, o_tx_fill: FIFO occupancy; o_rx_overflow: sticky dropped-byte flag

module uart_fifo_bridge_rx #(
    parameter int BW = 9,
    parameter int TIMER_BITS = 32,
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_uart,
    output logic          o_wr,
    output logic [BW-2:0] o_data
);
    localparam int CW = $clog2(BW + 1);
    localparam logic [TIMER_BITS-1:0] HALF = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [TIMER_BITS-1:0] FULL = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    logic [1:0] sync;
    logic busy;
    logic [CW-1:0] bit_cnt;
    logic [TIMER_BITS-1:0] timer;
    logic [BW-2:0] sh;
    logic line;
    assign line = sync[1];
    // bit_cnt 0 = mid start bit, 1..BW-1 = data bits LSB first, BW = stop bit
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync <= 2'b11;
            busy <= 1'b0;
            o_wr <= 1'b0;
            bit_cnt <= '0;
            timer <= '0;
        end else begin
            sync <= {sync[0], i_uart};
            o_wr <= 1'b0;
            if (!busy) begin
                if (!line) begin
                    busy <= 1'b1;
                    timer <= HALF;
                    bit_cnt <= '0;
                end
            end else if (timer != '0) begin
                timer <= timer - TIMER_BITS'(1);
            end else begin
                timer <= FULL;
                bit_cnt <= bit_cnt + CW'(1);
                if (bit_cnt == '0) begin
                    if (line) busy <= 1'b0;
                end else if (bit_cnt <= CW'(BW - 1)) begin
                    sh <= {line, sh[BW-2:1]};
                end else begin
                    busy <= 1'b0;
                    o_wr <= line;
                    o_data <= sh;
                end
            end
        end
    end
endmodule

module uart_fifo_bridge_tx #(
    parameter int BW = 9,
    parameter int TIMER_BITS = 32,
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [BW-2:0] i_data,
    output logic          o_uart,
    output logic          o_busy
);
    localparam int CW = $clog2(BW + 1);
    localparam logic [TIMER_BITS-1:0] FULL = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    logic [CW-1:0] cnt;
    logic [TIMER_BITS-1:0] timer;
    logic [BW-1:0] sh;
    // start bit is driven at load; each baud expiry shifts out the next bit, ones refill from the top
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_uart <= 1'b1;
            o_busy <= 1'b0;
            cnt <= '0;
            timer <= '0;
            sh <= '1;
        end else if (!o_busy) begin
            if (i_wr) begin
                o_busy <= 1'b1;
                o_uart <= 1'b0;
                sh <= {1'b1, i_data};
                timer <= FULL;
                cnt <= '0;
            end
        end else if (timer != '0) begin
            timer <= timer - TIMER_BITS'(1);
        end else begin
            timer <= FULL;
            o_uart <= sh[0];
            sh <= {1'b1, sh[BW-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(BW)) o_busy <= 1'b0;
        end
    end
endmodule

module uart_fifo_bridge_fifo #(
    parameter int W = 8,
    parameter int LG = 4
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [LG:0]  o_count,
    output logic         o_full,
    output logic         o_empty
);
    localparam logic [LG:0] DEPTH = (LG + 1)'(2 ** LG);
    logic [W-1:0] mem [2 ** LG];
    logic [LG-1:0] wp, rp;
    always_ff @(posedge clk)
        if (i_push) mem[wp] <= i_data;
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wp <= '0;
            rp <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wp <= wp + LG'(1);
            if (i_pop) rp <= rp + LG'(1);
            o_count <= o_count + (LG + 1)'(i_push) - (LG + 1)'(i_pop);
        end
    end
    assign o_data = mem[rp];
    assign o_full = o_count == DEPTH;
    assign o_empty = o_count == '0;
endmodule

module uart_fifo_bridge #(
    parameter int BW = 9,
    parameter int TIMER_BITS = 32,
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int LGFIFO = 4
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          uart_txd_in,
    output logic          uart_rxd_out,
    output logic          led0_b,
    input  logic          i_loopback,
    input  logic          i_wr_valid,
    input  logic [BW-2:0] i_wr_data,
    output logic          o_wr_ready,
    output logic          o_rd_valid,
    output logic [BW-2:0] o_rd_data,
    input  logic          i_rd_ready,
    output logic [LGFIFO:0] o_rx_fill,
    output logic [LGFIFO:0] o_tx_fill,
    output logic          o_rx_overflow
);
    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} drain_t;
    drain_t state, state_nx;
    logic loop_q, rx_wr, rx_full, rx_empty, rx_pop, rx_push;
    logic tx_full, tx_empty, tx_push, tx_valid, tx_busy, tx_ready, xfer;
    logic [BW-2:0] rx_byte, rx_head, tx_din, tx_head;

    // registered mode so a mode change applies from the following cycle
    always_ff @(posedge clk)
        loop_q <= i_loopback;

    uart_fifo_bridge_rx #(.BW(BW), .TIMER_BITS(TIMER_BITS), .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_rx (
        .clk(clk), .i_reset(i_reset), .i_uart(uart_txd_in), .o_wr(rx_wr), .o_data(rx_byte));

    assign xfer = !rx_empty && !tx_full;
    assign rx_pop = loop_q ? xfer : (o_rd_valid && i_rd_ready);
    // a full FIFO still takes the byte when a pop frees a slot in the same cycle
    assign rx_push = rx_wr && (!rx_full || rx_pop);
    assign o_rd_valid = !loop_q && !rx_empty;
    assign o_wr_ready = !loop_q && !tx_full;
    assign tx_push = loop_q ? xfer : (i_wr_valid && o_wr_ready);
    assign tx_din = loop_q ? rx_head : i_wr_data;
    assign o_rd_data = rx_head;

    uart_fifo_bridge_fifo #(.W(BW - 1), .LG(LGFIFO)) u_rx_fifo (
        .clk(clk), .i_reset(i_reset), .i_push(rx_push), .i_pop(rx_pop), .i_data(rx_byte),
        .o_data(rx_head), .o_count(o_rx_fill), .o_full(rx_full), .o_empty(rx_empty));

    uart_fifo_bridge_fifo #(.W(BW - 1), .LG(LGFIFO)) u_tx_fifo (
        .clk(clk), .i_reset(i_reset), .i_push(tx_push), .i_pop(tx_valid), .i_data(tx_din),
        .o_data(tx_head), .o_count(o_tx_fill), .o_full(tx_full), .o_empty(tx_empty));

    always_ff @(posedge clk)
        if (i_reset) o_rx_overflow <= 1'b0;
        else if (rx_wr && !rx_push) o_rx_overflow <= 1'b1;

    // drain FSM waits for tx to go busy and then idle, so each byte is issued exactly once
    always_ff @(posedge clk)
        state <= i_reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        unique case (state)
            IDLE: if (tx_ready && !tx_empty) begin
                tx_valid = 1'b1;
                state_nx = WAIT_LOW;
            end
            WAIT_LOW: state_nx = tx_ready ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: state_nx = tx_ready ? IDLE : WAIT_HIGH;
            default: state_nx = IDLE;
        endcase
    end

    uart_fifo_bridge_tx #(.BW(BW), .TIMER_BITS(TIMER_BITS), .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_tx (
        .clk(clk), .i_reset(i_reset), .i_wr(tx_valid), .i_data(tx_head), .o_uart(uart_rxd_out), .o_busy(tx_busy));

    assign tx_ready = !tx_busy;
    assign led0_b = uart_rxd_out;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed bench for uart_fifo_bridge at 16 clocks per baud, depth-4 FIFOs
module tb_uart_fifo_bridge;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic uart_txd_in = 1'b1;
    logic uart_rxd_out, led0_b;
    logic i_loopback = 1'b1;
    logic i_wr_valid = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic o_wr_ready, o_rd_valid, i_rd_ready = 1'b0, o_rx_overflow;
    logic [7:0] o_rd_data;
    logic [2:0] o_rx_fill, o_tx_fill;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.BW(9), .TIMER_BITS(32), .CLOCKS_PER_BAUD(CPB), .LGFIFO(2)) dut (
        .clk(clk), .i_reset(i_reset), .uart_txd_in(uart_txd_in), .uart_rxd_out(uart_rxd_out),
        .led0_b(led0_b), .i_loopback(i_loopback), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_rx_fill(o_rx_fill), .o_tx_fill(o_tx_fill), .o_rx_overflow(o_rx_overflow));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_txd_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_txd_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_txd_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        int n;
        n = 0;
        while (uart_rxd_out !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, {31'd0, uart_rxd_out}, 32'd0);
        if (uart_rxd_out !== 1'b0) return;
        repeat (CPB / 2) @(negedge clk);
        check({tag, "_startmid"}, {31'd0, uart_rxd_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_rxd_out;
        end
        repeat (CPB) @(negedge clk);
        check({tag, "_stop"}, {31'd0, uart_rxd_out}, 32'd1);
        check({tag, "_byte"}, {24'd0, b}, {24'd0, exp});
    endtask

    task automatic host_write(input logic [7:0] d);
        check("wr_ready_before_write", {31'd0, o_wr_ready}, 32'd1);
        i_wr_valid = 1'b1;
        i_wr_data = d;
        @(negedge clk);
        i_wr_valid = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, o_rd_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, o_rd_data}, {24'd0, exp});
        i_rd_ready = 1'b1;
        @(negedge clk);
        i_rd_ready = 1'b0;
    endtask

    initial begin
        int n;
        int lows;
        logic [7:0] bp_data [5];
        bp_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};

        // reset in loopback mode
        do_reset();
        check("rst_rx_fill", {29'd0, o_rx_fill}, 32'd0);
        check("rst_tx_fill", {29'd0, o_tx_fill}, 32'd0);
        check("rst_overflow", {31'd0, o_rx_overflow}, 32'd0);
        check("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
        check("rst_wr_ready_loop", {31'd0, o_wr_ready}, 32'd0);
        check("rst_line_idle", {31'd0, uart_rxd_out}, 32'd1);
        check("led_mirror", {31'd0, led0_b}, 32'd1);

        // loopback echo of 0x55
        fork
            send_byte(8'h55);
            expect_frame("echo", 8'h55);
        join
        check("echo_overflow", {31'd0, o_rx_overflow}, 32'd0);
        check("echo_rd_valid", {31'd0, o_rd_valid}, 32'd0);

        // host mode TX: three back-to-back writes; the first is handed to tx one cycle after its push
        i_loopback = 1'b0;
        do_reset();
        check("host_wr_ready", {31'd0, o_wr_ready}, 32'd1);
        host_write(8'hA1);
        host_write(8'hB2);
        host_write(8'hC3);
        check("host_tx_fill", {29'd0, o_tx_fill}, 32'd2);
        expect_frame("host_a1", 8'hA1);
        expect_frame("host_b2", 8'hB2);
        expect_frame("host_c3", 8'hC3);
        check("host_tx_fill_end", {29'd0, o_tx_fill}, 32'd0);

        // RX overflow: six bytes into a depth-4 FIFO with no reads
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        repeat (2) @(negedge clk);
        check("ovf_rx_fill", {29'd0, o_rx_fill}, 32'd4);
        check("ovf_flag", {31'd0, o_rx_overflow}, 32'd1);
        for (int i = 1; i <= 4; i++) host_read("ovf_read", 8'(i));
        check("ovf_empty", {31'd0, o_rd_valid}, 32'd0);
        check("ovf_sticky", {31'd0, o_rx_overflow}, 32'd1);

        // full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        check("sim_full", {29'd0, o_rx_fill}, 32'd4);
        fork
            send_byte(8'h7E);
            begin
                n = 0;
                while (dut.rx_wr !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("sim_rx_strobe", {31'd0, dut.rx_wr}, 32'd1);
                i_rd_ready = 1'b1;
                @(negedge clk);
                i_rd_ready = 1'b0;
            end
        join
        check("sim_fill", {29'd0, o_rx_fill}, 32'd4);
        check("sim_overflow", {31'd0, o_rx_overflow}, 32'd0);
        host_read("sim_r12", 8'h12);
        host_read("sim_r13", 8'h13);
        host_read("sim_r14", 8'h14);
        host_read("sim_r7e", 8'h7E);
        check("sim_empty", {31'd0, o_rd_valid}, 32'd0);

        // TX backpressure: frame in flight, then fill the FIFO and hold a fifth write
        do_reset();
        host_write(8'h3C);
        repeat (5) @(negedge clk);
        check("bp_inflight_fill", {29'd0, o_tx_fill}, 32'd0);
        for (int i = 0; i < 4; i++) host_write(bp_data[i]);
        check("bp_full_fill", {29'd0, o_tx_fill}, 32'd4);
        check("bp_wr_ready_full", {31'd0, o_wr_ready}, 32'd0);
        i_wr_valid = 1'b1;
        i_wr_data = bp_data[4];
        n = 0;
        while (o_wr_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("bp_accept", {31'd0, o_wr_ready}, 32'd1);
        @(negedge clk);
        i_wr_valid = 1'b0;
        check("bp_refill", {29'd0, o_tx_fill}, 32'd4);
        for (int i = 0; i < 5; i++) expect_frame("bp_frame", bp_data[i]);
        check("bp_drained", {29'd0, o_tx_fill}, 32'd0);

        // reset in the middle of a 0xF0 frame
        repeat (4) @(negedge clk);
        host_write(8'hF0);
        repeat (40) @(negedge clk);
        check("mid_line_busy", {31'd0, uart_rxd_out}, 32'd0);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("mid_rx_fill", {29'd0, o_rx_fill}, 32'd0);
        check("mid_tx_fill", {29'd0, o_tx_fill}, 32'd0);
        check("mid_rd_valid", {31'd0, o_rd_valid}, 32'd0);
        check("mid_overflow", {31'd0, o_rx_overflow}, 32'd0);
        check("mid_line_high", {31'd0, uart_rxd_out}, 32'd1);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_rxd_out !== 1'b1) lows++;
        end
        check("mid_no_frames", 32'(lows), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
